// File: rtl/gcd_unit_arbiter.sv
// Shares one GCD unit between p_num_reqs requesters: round-robin request grant,
// with a tag FIFO that steers the in-order GCD responses back to the issuing port.
module gcd_unit_arbiter #(
  parameter int p_num_reqs     = 2,
  parameter int p_max_inflight = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [p_num_reqs-1:0]    in_req_val,
  output logic [p_num_reqs-1:0]    in_req_rdy,
  input  logic [32*p_num_reqs-1:0] in_req_msg,
  output logic [p_num_reqs-1:0]    in_resp_val,
  input  logic [p_num_reqs-1:0]    in_resp_rdy,
  output logic [16*p_num_reqs-1:0] in_resp_msg,
  output logic                     gcd_req_val,
  input  logic                     gcd_req_rdy,
  output logic [31:0]              gcd_req_msg,
  input  logic                     gcd_resp_val,
  output logic                     gcd_resp_rdy,
  input  logic [15:0]              gcd_resp_msg
);
  localparam int iw = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;
  localparam int fw = $clog2(p_max_inflight);
  localparam logic [iw:0]   num_reqs = (iw+1)'(p_num_reqs);
  localparam logic [iw-1:0] last_idx = iw'(p_num_reqs - 1);

  logic [iw-1:0] rr_ptr;
  logic [iw-1:0] tag_mem [p_max_inflight];
  logic [fw:0]   wr_ptr;
  logic [fw:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          any_val;
  logic          req_fire;
  logic          resp_fire;
  logic [iw-1:0] grant_idx;
  logic [iw-1:0] head;
  logic [iw:0]   cand;
  logic          found;

  // Handshakes are val/rdy: a transfer happens in a cycle where both are high;
  // val never depends on rdy of the same channel, rdy may depend on val.

  assign full    = (wr_ptr[fw] != rd_ptr[fw]) && (wr_ptr[fw-1:0] == rd_ptr[fw-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign head    = tag_mem[rd_ptr[fw-1:0]];
  assign any_val = |in_req_val;

  // First valid port at or after rr_ptr, wrapping modulo p_num_reqs.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < p_num_reqs; k++) begin
      cand = {1'b0, rr_ptr} + (iw+1)'(k);
      if (cand >= num_reqs) cand = cand - num_reqs;
      if (!found && in_req_val[cand[iw-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[iw-1:0];
      end
    end
  end

  assign gcd_req_val  = !reset && any_val && !full;
  assign gcd_resp_rdy = !reset && !empty && in_resp_rdy[head];
  assign req_fire     = gcd_req_val && gcd_req_rdy;
  assign resp_fire    = gcd_resp_val && gcd_resp_rdy;
  assign in_resp_msg  = {p_num_reqs{gcd_resp_msg}};

  always_comb begin
    gcd_req_msg = '0;
    in_req_rdy  = '0;
    in_resp_val = '0;
    for (int i = 0; i < p_num_reqs; i++) begin
      if (any_val && (grant_idx == iw'(i))) begin
        gcd_req_msg   = in_req_msg[32*i +: 32];
        in_req_rdy[i] = req_fire;
      end
      in_resp_val[i] = !reset && gcd_resp_val && !empty && (head == iw'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (req_fire) begin
        wr_ptr <= wr_ptr + (fw+1)'(1);
        rr_ptr <= (grant_idx == last_idx) ? '0 : grant_idx + iw'(1);
      end
      if (resp_fire) rd_ptr <= rd_ptr + (fw+1)'(1);
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (!reset && req_fire) tag_mem[wr_ptr[fw-1:0]] <= grant_idx;
  end

  // A GCD response with no outstanding tag has no owner to go to.
  resp_without_tag: assert property (@(posedge clk) disable iff (reset)
    !(gcd_resp_val && empty));

endmodule

// File: doc/gcd_unit_arbiter.md
Name: gcd_unit_arbiter

Overview:
- Shares one GCD unit between p_num_reqs independent requesters.
- Each requester uses the same val/rdy request and response message format as the GCD unit.
  - Request message: 32 bits, {a[31:16], b[15:0]}.
  - Response message: 16 bits, gcd result.
- Requests are granted round-robin and forwarded to the single GCD unit.
- The GCD unit returns responses in order. An internal tag FIFO records which requester issued each request, and each response is routed back to that requester.
- The block sits between the per-port software shims and the shared HostGcdUnit datapath.

Parameters:
p_num_reqs      2   number of requester ports (2..8)
p_max_inflight  4   tag FIFO depth = max requests outstanding in the GCD unit (power of 2, >=2)

Ports:
clk          input   1                 clock, all state updates on posedge
reset        input   1                 synchronous, active-high
in_req_val   input   p_num_reqs        per-port request valid
in_req_rdy   output  p_num_reqs        per-port request ready
in_req_msg   input   32*p_num_reqs     per-port request; port i at [32*i+31:32*i]
in_resp_val  output  p_num_reqs        per-port response valid
in_resp_rdy  input   p_num_reqs        per-port response ready
in_resp_msg  output  16*p_num_reqs     per-port response; every port sees gcd_resp_msg
gcd_req_val  output  1                 request valid to GCD unit
gcd_req_rdy  input   1                 GCD unit ready
gcd_req_msg  output  32                muxed request message
gcd_resp_val input   1                 GCD response valid
gcd_resp_rdy output  1                 ready to GCD unit
gcd_resp_msg input   16                GCD result

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
- State:
  - rr_ptr, clog2(p_num_reqs) bits.
  - Tag FIFO: p_max_inflight entries of clog2(p_num_reqs) bits.
  - wr_ptr and rd_ptr, each one bit wider than the FIFO index.
  - full = (pointers differ only in MSB). empty = (wr_ptr == rd_ptr).
- Reset: rr_ptr=0, FIFO empty. While reset is high, all *_val and *_rdy outputs are 0. Reset mid-operation discards all in-flight tags; the GCD unit is reset by the same signal.
- Grant (combinational):
  - Search in_req_val starting at rr_ptr, wrapping modulo p_num_reqs; the first valid port is grant_idx.
  - any_val = |in_req_val.
- Request path:
  - gcd_req_val = any_val & !full.
  - gcd_req_msg = in_req_msg[grant_idx], or 0 when !any_val.
  - in_req_rdy[i] = (i==grant_idx) & any_val & !full & gcd_req_rdy.
  - Request fire = gcd_req_val & gcd_req_rdy. On fire: push grant_idx into the FIFO, increment wr_ptr, set rr_ptr = (grant_idx+1) mod p_num_reqs.
  - No fire means rr_ptr holds.
  - Zero-cycle latency: request and grant are combinational; the FIFO push is registered.
- Full: a push is blocked whenever full=1, even if a pop occurs in the same cycle. No bypass.
- Response path:
  - head = fifo[rd_ptr].
  - in_resp_val[i] = gcd_resp_val & !empty & (i==head).
  - gcd_resp_rdy = !empty & in_resp_rdy[head].
  - Response fire: pop the FIFO (rd_ptr+1).
  - A non-head port is never valid. A stalled head port blocks all responses (strict in-order).
- Empty: gcd_resp_rdy=0. A gcd_resp_val arriving while empty is held and not consumed (protocol violation; assertion in simulation).
- Simultaneous push and pop when neither full nor empty: both occur, and occupancy is unchanged.
- Pointer wrap: wr_ptr/rd_ptr wrap naturally at 2*p_max_inflight. rr_ptr wraps from p_num_reqs-1 to 0.
- Combinational paths:
  - in_req_rdy depends on in_req_val of other ports.
  - No in_req_val -> in_req_rdy path exists on the same port, beyond the grant.
  - No combinational path from gcd_resp to gcd_req.

Test Plan:
1. Single port 0 sends 0x000F0005 and 0x001B0009; port 1 idle -> gcd_req_msg shows both in order, port 0 receives 0x0005 then 0x0009, and in_resp_val[1] never asserts.
2. Both ports hold val continuously with distinct streams (port0 0x00300012, port1 0x0064004B), src/sink delay 0 -> grants alternate 0,1,0,1. Results 0x0006 go to port 0 and 0x0019 to port 1, each 4 times.
3. gcd_resp_rdy path stalled (in_resp_rdy all 0), both ports sending -> exactly p_max_inflight=4 requests fire. gcd_req_val then stays 0 until in_resp_rdy[head] rises; one response pop re-enables one push on the following cycle.
4. Port 0 issues a request, then port 1 issues one. Hold in_resp_rdy[0]=0 with in_resp_rdy[1]=1 -> port 1 receives nothing until port 0 accepts its response (in-order head blocking).
5. Reset asserted for 1 cycle with 3 requests outstanding -> next cycle all outputs val/rdy 0, FIFO empty, rr_ptr=0. A fresh request 0x00080004 then returns 0x0004 to the correct port.
6. Random src/sink delays 0..10 on both ports, 1000 messages each -> all responses arrive at the originating port in issue order; the bench finishes within 20000 cycles.
